// File: rtl/cam_config_sequencer.sv
// Stereo camera configuration sequencer.
// Walks a register table in a synchronous ROM and issues one SCCB write per
// entry through a shared sender, first on the left camera bus, then on the
// right. Guard and delay intervals keep the bus quiet before each switch.
module cam_config_sequencer #(
   parameter logic [7:0] CAM_ID       = 8'h42,
   parameter int         XFER_CYCLES  = 8448,
   parameter int         DELAY_CYCLES = 2_500_000,
   parameter int         ADDR_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic              send,
   input  logic              taken,
   output logic [7:0]        id,
   output logic [7:0]        reg_addr,
   output logic [7:0]        value,
   output logic              bus_sel,
   output logic              busy,
   output logic              done
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_SEND   = 3'd3;
   localparam logic [2:0] ST_GUARD  = 3'd4;
   localparam logic [2:0] ST_DELAY  = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;

   localparam logic [15:0]       END_MARK   = 16'hFFFF;
   localparam logic [15:0]       DELAY_MARK = 16'hFFF0;
   localparam logic [31:0]       XFER_LOAD  = 32'(XFER_CYCLES - 1);
   localparam logic [31:0]       DELAY_LOAD = 32'(DELAY_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX   = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [2:0]  state;
   logic [31:0] cnt;
   logic        wait_over;
   logic        end_hit;

   // The ID never changes; both cameras share the same SCCB address.
   assign id = CAM_ID;

   // End of the current camera's table: explicit end marker, or an interval
   // expiring on the last ROM address (the address never wraps).
   always_comb begin
      wait_over = 1'b0;
      end_hit   = 1'b0;
      if ((state == ST_GUARD) || (state == ST_DELAY)) begin
         wait_over = (cnt == 32'd0);
      end else begin
         wait_over = 1'b0;
      end
      if ((state == ST_DECODE) && (rom_data == END_MARK)) begin
         end_hit = 1'b1;
      end else if (wait_over && (rom_addr == ADDR_MAX)) begin
         end_hit = 1'b1;
      end else begin
         end_hit = 1'b0;
      end
   end

   // Sequencer state machine and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= 32'd0;
         rom_addr <= '0;
         send     <= 1'b0;
         reg_addr <= 8'd0;
         value    <= 8'd0;
         bus_sel  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else if (end_hit) begin
         // Bus switches only here, after a completed guard or on a marker.
         if (bus_sel == 1'b0) begin
            bus_sel  <= 1'b1;
            rom_addr <= '0;
            state    <= ST_FETCH;
         end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
         end
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  rom_addr <= '0;
                  bus_sel  <= 1'b0;
                  done     <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               state <= ST_DECODE;
            end
            ST_DECODE: begin
               if (rom_data == DELAY_MARK) begin
                  cnt   <= DELAY_LOAD;
                  state <= ST_DELAY;
               end else begin
                  reg_addr <= rom_data[15:8];
                  value    <= rom_data[7:0];
                  send     <= 1'b1;
                  state    <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (taken) begin
                  send  <= 1'b0;
                  cnt   <= XFER_LOAD;
                  state <= ST_GUARD;
               end
            end
            ST_GUARD, ST_DELAY: begin
               if (wait_over) begin
                  rom_addr <= rom_addr + ADDR_ONE;
                  state    <= ST_FETCH;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               send  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
